// File: rtl/rename_unit_pkg.sv
// Shared types and sizing helpers for the register rename unit.
package rename_unit_pkg;

  localparam int ARCH_REGS_DEF = 32;
  localparam int PHYS_REGS_DEF = 64;

  function automatic int areg_w(input int arch_regs);
    return $clog2(arch_regs);
  endfunction

  function automatic int preg_w(input int phys_regs);
    return $clog2(phys_regs);
  endfunction

  typedef logic [areg_w(ARCH_REGS_DEF)-1:0] areg_t;
  typedef logic [preg_w(PHYS_REGS_DEF)-1:0] preg_t;

endpackage

// File: rtl/rename_free_list.sv
// Circular FIFO of free physical registers, preloaded with BASE..BASE+DEPTH-1.
module rename_free_list #(
  parameter int DEPTH  = 32,
  parameter int PREG_W = 6,
  parameter int BASE   = 32,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              push,
  input  logic [PREG_W-1:0] push_preg,
  input  logic              pop,
  output logic [PREG_W-1:0] head_preg,
  output logic [CNT_W-1:0]  count,
  output logic              err_ovf
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PREG_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  head, tail;
  logic              full, do_push, do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && (count != '0);
  // A push into a full list only lands if a pop frees a slot in the same cycle.
  assign do_push   = push && (!full || do_pop);
  assign head_preg = mem[head];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      // NOTE: this storage must come out of reset holding the initial free registers, so it is reset explicitly.
      for (int i = 0; i < DEPTH; i++) mem[i] <= PREG_W'(BASE + i);
      head    <= '0;
      tail    <= '0;
      count   <= CNT_W'(DEPTH);
      err_ovf <= 1'b0;
    end else begin
      if (do_push) begin
        mem[tail] <= push_preg;
        tail      <= next_ptr(tail);
      end
      if (do_pop) head <= next_ptr(head);
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
      if (push && !do_push) err_ovf <= 1'b1;
    end
  end

endmodule

// File: rtl/rename_unit.sv
// Register rename unit: RAT, per-register ready bits and a free list.
// Optional macro RENAME_WB_BYPASS_EN forwards same-cycle writeback into source readiness.
module rename_unit
  import rename_unit_pkg::*;
#(
  parameter  int ARCH_REGS = ARCH_REGS_DEF,
  parameter  int PHYS_REGS = PHYS_REGS_DEF,
  localparam int AREG_W    = areg_w(ARCH_REGS),
  localparam int PREG_W    = preg_w(PHYS_REGS)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              ren_valid,
  output logic              ren_ready,
  input  logic [AREG_W-1:0] ren_sr1,
  input  logic [AREG_W-1:0] ren_sr2,
  input  logic [AREG_W-1:0] ren_dr,
  input  logic              ren_wr,
  output logic              out_valid,
  output logic [PREG_W-1:0] out_sr1_p,
  output logic [PREG_W-1:0] out_sr2_p,
  output logic [PREG_W-1:0] out_dr_p,
  output logic [PREG_W-1:0] out_old_dr_p,
  output logic              out_s1_ready,
  output logic              out_s2_ready,
  input  logic              wb_valid,
  input  logic [PREG_W-1:0] wb_preg,
  input  logic              cmt_valid,
  input  logic [PREG_W-1:0] cmt_preg,
  output logic              err_ovf
);

  localparam int FL_DEPTH = PHYS_REGS - ARCH_REGS;
  localparam int CNT_W    = $clog2(FL_DEPTH + 1);

  logic [PREG_W-1:0]    rat [ARCH_REGS];
  logic [PHYS_REGS-1:0] rdy;
  logic [PREG_W-1:0]    fl_head, src1_p, src2_p;
  logic [CNT_W-1:0]     fl_count;
  logic                 accept, alloc, src1_rdy, src2_rdy;

  assign ren_ready = (fl_count != '0) || !(ren_wr && (ren_dr != '0));
  assign accept    = ren_valid && ren_ready;
  assign alloc     = accept && ren_wr && (ren_dr != '0);

  // Sources read the RAT as it stood before this instruction's own update.
  assign src1_p = rat[ren_sr1];
  assign src2_p = rat[ren_sr2];

`ifdef RENAME_WB_BYPASS_EN
  assign src1_rdy = rdy[src1_p] || (wb_valid && (wb_preg == src1_p));
  assign src2_rdy = rdy[src2_p] || (wb_valid && (wb_preg == src2_p));
`else
  assign src1_rdy = rdy[src1_p];
  assign src2_rdy = rdy[src2_p];
`endif

  rename_free_list #(
    .DEPTH  (FL_DEPTH),
    .PREG_W (PREG_W),
    .BASE   (ARCH_REGS),
    .CNT_W  (CNT_W)
  ) u_free_list (
    .clk       (clk),
    .rstn      (rstn),
    .push      (cmt_valid && (cmt_preg != '0)),
    .push_preg (cmt_preg),
    .pop       (alloc),
    .head_preg (fl_head),
    .count     (fl_count),
    .err_ovf   (err_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < ARCH_REGS; i++) rat[i] <= PREG_W'(i);
      rdy          <= '1;
      out_valid    <= 1'b0;
      out_sr1_p    <= '0;
      out_sr2_p    <= '0;
      out_dr_p     <= '0;
      out_old_dr_p <= '0;
      out_s1_ready <= 1'b0;
      out_s2_ready <= 1'b0;
    end else begin
      // NOTE: non-blocking order matters here: the allocation clear is written last so it overrides a writeback set.
      if (wb_valid && (wb_preg != '0)) rdy[wb_preg] <= 1'b1;
      if (alloc) begin
        rat[ren_dr]  <= fl_head;
        rdy[fl_head] <= 1'b0;
      end

      out_valid    <= accept;
      out_sr1_p    <= accept ? src1_p : '0;
      out_sr2_p    <= accept ? src2_p : '0;
      out_s1_ready <= accept && src1_rdy;
      out_s2_ready <= accept && src2_rdy;
      out_dr_p     <= alloc ? fl_head : '0;
      out_old_dr_p <= alloc ? rat[ren_dr] : '0;
    end
  end

endmodule

// File: tb/tb_rename_unit.sv
// Directed self-checking bench for rename_unit with hand-computed expectations.
module tb_rename_unit;
  import rename_unit_pkg::*;

  logic  clk = 1'b0;
  logic  rstn;
  logic  ren_valid, ren_ready, ren_wr;
  areg_t ren_sr1, ren_sr2, ren_dr;
  logic  out_valid, out_s1_ready, out_s2_ready;
  preg_t out_sr1_p, out_sr2_p, out_dr_p, out_old_dr_p;
  logic  wb_valid, cmt_valid, err_ovf;
  preg_t wb_preg, cmt_preg;

  int vectors     = 0;
  int miscompares = 0;

`ifdef RENAME_WB_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif

  rename_unit dut (
    .clk          (clk),
    .rstn         (rstn),
    .ren_valid    (ren_valid),
    .ren_ready    (ren_ready),
    .ren_sr1      (ren_sr1),
    .ren_sr2      (ren_sr2),
    .ren_dr       (ren_dr),
    .ren_wr       (ren_wr),
    .out_valid    (out_valid),
    .out_sr1_p    (out_sr1_p),
    .out_sr2_p    (out_sr2_p),
    .out_dr_p     (out_dr_p),
    .out_old_dr_p (out_old_dr_p),
    .out_s1_ready (out_s1_ready),
    .out_s2_ready (out_s2_ready),
    .wb_valid     (wb_valid),
    .wb_preg      (wb_preg),
    .cmt_valid    (cmt_valid),
    .cmt_preg     (cmt_preg),
    .err_ovf      (err_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int sr1, input int sr2, input int dr, input logic wr);
    ren_sr1   = areg_t'(sr1);
    ren_sr2   = areg_t'(sr2);
    ren_dr    = areg_t'(dr);
    ren_wr    = wr;
    ren_valid = 1'b1;
    tick();
    ren_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input int sr1p, input int sr2p, input int drp,
                           input int oldp, input logic s1r, input logic s2r);
    check({tag, ".valid"},  32'(out_valid),    32'd1);
    check({tag, ".sr1_p"},  32'(out_sr1_p),    32'(sr1p));
    check({tag, ".sr2_p"},  32'(out_sr2_p),    32'(sr2p));
    check({tag, ".dr_p"},   32'(out_dr_p),     32'(drp));
    check({tag, ".old_dr"}, 32'(out_old_dr_p), 32'(oldp));
    check({tag, ".s1_rdy"}, 32'(out_s1_ready), 32'(s1r));
    check({tag, ".s2_rdy"}, 32'(out_s2_ready), 32'(s2r));
  endtask

  initial begin
    rstn = 1'b0; ren_valid = 1'b0; ren_wr = 1'b1;
    ren_sr1 = '0; ren_sr2 = '0; ren_dr = areg_t'(3);
    wb_valid = 1'b0; wb_preg = '0; cmt_valid = 1'b0; cmt_preg = '0;
    tick();
    tick();
    check("rst.valid",  32'(out_valid), 32'd0);
    check("rst.dr_p",   32'(out_dr_p),  32'd0);
    check("rst.ovf",    32'(err_ovf),   32'd0);
    check("rst.ready",  32'(ren_ready), 32'd1);
    rstn = 1'b1;
    tick();

    // First allocation takes the free-list head (32); source mappings are identity.
    issue(1, 2, 3, 1'b1);
    check_out("alloc1", 1, 2, 32, 3, 1'b1, 1'b1);
    // Source reads the old mapping of its own destination.
    issue(3, 0, 3, 1'b1);
    check_out("self", 32, 0, 33, 32, 1'b0, 1'b1);

    // Same-cycle writeback to the source's mapping: only forwarded with the bypass.
    wb_valid = 1'b1; wb_preg = preg_t'(33);
    issue(3, 0, 0, 1'b0);
    wb_valid = 1'b0;
    check_out("wb_same", 33, 0, 0, 0, BYP, 1'b1);
    issue(3, 0, 0, 1'b0);
    check_out("wb_after", 33, 0, 0, 0, 1'b1, 1'b1);

    // Writeback and allocation of the same register: the allocation clear wins.
    wb_valid = 1'b1; wb_preg = preg_t'(34);
    issue(1, 2, 4, 1'b1);
    wb_valid = 1'b0;
    check_out("wb_alloc", 1, 2, 34, 4, 1'b1, 1'b1);
    issue(4, 0, 0, 1'b0);
    check_out("clr_wins", 34, 0, 0, 0, 1'b0, 1'b1);

    // Destination r0 never allocates; the following allocation gets the next head.
    issue(0, 0, 0, 1'b1);
    check_out("dr0", 0, 0, 0, 0, 1'b1, 1'b1);
    issue(1, 1, 5, 1'b1);
    check_out("after_dr0", 1, 1, 35, 5, 1'b1, 1'b1);

    // Drain the remaining 28 entries.
    for (int i = 0; i < 28; i++) begin
      issue(0, 0, 8, 1'b1);
      check($sformatf("drain%0d.dr_p", i),   32'(out_dr_p),     32'(36 + i));
      check($sformatf("drain%0d.old_dr", i), 32'(out_old_dr_p), (i == 0) ? 32'd8 : 32'(35 + i));
    end
    ren_wr = 1'b1; ren_dr = areg_t'(5); #1;
    check("empty.ready_wr", 32'(ren_ready), 32'd0);
    ren_wr = 1'b0; #1;
    check("empty.ready_nowr", 32'(ren_ready), 32'd1);
    ren_wr = 1'b1; ren_dr = '0; #1;
    check("empty.ready_dr0", 32'(ren_ready), 32'd1);

    // Commit on an empty list blocks a same-cycle allocation; the next one reuses it.
    cmt_valid = 1'b1; cmt_preg = preg_t'(5);
    ren_valid = 1'b1; ren_wr = 1'b1; ren_dr = areg_t'(6); #1;
    check("cmt_empty.ready", 32'(ren_ready), 32'd0);
    tick();
    cmt_valid = 1'b0; ren_valid = 1'b0;
    check("cmt_empty.no_acc", 32'(out_valid), 32'd0);
    issue(0, 0, 6, 1'b1);
    check_out("reuse", 0, 0, 5, 6, 1'b1, 1'b1);

    // Refill to full, then overflow with one more commit.
    for (int i = 0; i < 32; i++) begin
      cmt_valid = 1'b1; cmt_preg = preg_t'(32 + i);
      tick();
    end
    cmt_valid = 1'b0;
    check("full.no_ovf", 32'(err_ovf), 32'd0);
    cmt_valid = 1'b1; cmt_preg = preg_t'(7);
    tick();
    cmt_valid = 1'b0;
    check("ovf.flag", 32'(err_ovf), 32'd1);
    tick();
    check("ovf.sticky", 32'(err_ovf), 32'd1);

    // The dropped push must not appear: exactly 32 entries in commit order.
    for (int i = 0; i < 32; i++) begin
      issue(0, 0, 9, 1'b1);
      check($sformatf("wrap%0d.dr_p", i), 32'(out_dr_p), 32'(32 + i));
    end
    ren_wr = 1'b1; ren_dr = areg_t'(9); #1;
    check("wrap.empty", 32'(ren_ready), 32'd0);

    // Reset during an accepted allocation discards output and mappings.
    rstn = 1'b0;
    ren_valid = 1'b1; ren_wr = 1'b1; ren_dr = areg_t'(3);
    tick();
    ren_valid = 1'b0;
    check("midrst.valid", 32'(out_valid), 32'd0);
    check("midrst.dr_p",  32'(out_dr_p),  32'd0);
    check("midrst.ovf",   32'(err_ovf),   32'd0);
    rstn = 1'b1;
    tick();
    issue(3, 9, 0, 1'b0);
    check_out("midrst.map", 3, 9, 0, 0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/rename_unit.md
RENAME_UNIT -- requirements
Module: rename_unit

Interface
REQ-001 SHALL have parameter ARCH_REGS, default 32: architectural register count.
REQ-002 SHALL have parameter PHYS_REGS, default 64: physical register count, greater than ARCH_REGS.
REQ-003 SHALL have derived widths AREG_W = clog2(ARCH_REGS) and PREG_W = clog2(PHYS_REGS).
REQ-004 clk  in  1  single clock; all state changes on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 ren_valid  in  1  decode presents an instruction.
REQ-007 ren_ready  out  1  rename can accept an instruction.
REQ-008 ren_sr1, ren_sr2, ren_dr  in  AREG_W each  architectural source and destination registers.
REQ-009 ren_wr  in  1  instruction writes ren_dr.
REQ-010 out_valid  out  1  renamed result valid.
REQ-011 out_sr1_p, out_sr2_p, out_dr_p, out_old_dr_p  out  PREG_W each  mapped sources, new destination, previous destination mapping.
REQ-012 out_s1_ready, out_s2_ready  out  1 each  source operand available.
REQ-013 wb_valid  in  1; wb_preg  in  PREG_W  writeback marks wb_preg ready.
REQ-014 cmt_valid  in  1; cmt_preg  in  PREG_W  commit frees cmt_preg.
REQ-015 err_ovf  out  1  sticky free-list overflow flag.

Function
REQ-016 State SHALL be: RAT (ARCH_REGS x PREG_W); ready bit per physical register; circular free-list FIFO of depth PHYS_REGS-ARCH_REGS with head, tail and count.
REQ-017 Accept SHALL occur when ren_valid and ren_ready are both high.
REQ-018 ren_ready SHALL equal (free count > 0) OR NOT (ren_wr AND ren_dr != 0).
REQ-019 Outputs SHALL be registered with 1-cycle latency: out_valid is high in the cycle after an accept, otherwise low.
REQ-020 Sources SHALL read the RAT before the same instruction's destination update, so ren_sr1 == ren_dr yields the old mapping.
REQ-021 On accept with ren_wr and ren_dr != 0, the unit SHALL: pop the free-list head to out_dr_p; output the previous RAT[ren_dr] on out_old_dr_p; write RAT[ren_dr]; clear ready of the new register.
REQ-022 Otherwise out_dr_p and out_old_dr_p SHALL be 0, with no pop.
REQ-023 Architectural register 0 SHALL always map to physical register 0 with ready = 1.
REQ-024 wb_valid SHALL set ready[wb_preg]; if the same register is also being allocated in that cycle, the clear from allocation wins.
REQ-025 cmt_valid with cmt_preg != 0 SHALL push cmt_preg at the tail; same-cycle push and pop SHALL keep the count unchanged and both take effect.
REQ-026 A push when the count is full and there is no pop in that cycle SHALL be dropped and SHALL set err_ovf.
REQ-027 Head and tail SHALL wrap modulo the FIFO depth.

Reset
REQ-028 While rstn is low at a clock edge: RAT[i] = i; all ready bits = 1; free list holds ARCH_REGS..PHYS_REGS-1 in order, head = 0, count = full; out_valid = 0; all out_* = 0; err_ovf = 0.
REQ-029 Reset asserted mid-operation SHALL discard the in-flight output and all mappings within that same edge.

Configuration
REQ-030 Macro RENAME_WB_BYPASS_EN, defined: a same-cycle wb_valid whose wb_preg matches a source's mapping SHALL force that out_sN_ready to 1.
REQ-031 RENAME_WB_BYPASS_EN, undefined: source ready reflects only ready bits registered before that cycle.

Structure
REQ-032 The shared package SHALL hold the ARCH_REGS/PHYS_REGS defaults, the width functions, and the typedefs areg_t and preg_t.
REQ-033 The free list SHALL be one sub-module named rename_free_list (push, pop, count, overflow).

Verification
REQ-034 Reset, then accept sr1=1, sr2=2, dr=3, wr=1 -> next cycle: sr1_p=1, sr2_p=2, dr_p=32, old_dr_p=3, s1_ready=1, s2_ready=1.
REQ-035 Then accept sr1=3, dr=3 -> sr1_p=32, s1_ready=0, dr_p=33, old_dr_p=32.
REQ-036 Allocate 32 times without commit -> ren_ready=0 while ren_wr=1 with dr!=0; with ren_wr=0 ren_ready=1.
REQ-037 On the empty list, commit cmt_preg=5 and accept with wr=1 in the same cycle -> no accept that cycle; the next accept gets dr_p=5.
REQ-038 wb_valid, wb_preg=32 in the same cycle as a lookup of sr1 mapped to 32 -> s1_ready=1 only when RENAME_WB_BYPASS_EN is defined.
REQ-039 Commit with a full free list -> err_ovf=1 and the count is unchanged; dr=0 with wr=1 -> dr_p=0 and no pop.
